// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, byte-lane load/store on a word-organised
// data memory, and the MEM/WB register feeding writeback and forwarding.
module memory_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] EX_AluRES,
  input  logic [31:0] EX_store_data,
  input  logic [4:0]  EX_rd,
  input  logic [2:0]  EX_funct3,
  input  logic        EX_WriteBack,
  input  logic        EX_MemoryRead,
  input  logic        EX_MemoryWrite,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  EXMEM_rd,
  output logic [31:0] EXMEM_AluRES,
  output logic        EXMEM_WriteBack,
  output logic [4:0]  MEMWB_rd,
  output logic [31:0] MEMWB_AluRES,
  output logic        MEMWB_WriteBack,
  output logic        MEMWB_fault
);

  logic [31:0] mem [2**ADDR_W];

  logic        exmem_read;
  logic        exmem_write;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_store_data;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       rdata;
  logic [31:0]       byte_shift;
  logic [31:0]       half_shift;
  logic [31:0]       load_val;
  logic              misaligned;
  logic              illegal;
  logic              fault;
  logic              do_store;
  logic [3:0]        byte_en;
  logic [31:0]       wdata;

  assign word_idx = EXMEM_AluRES[ADDR_W+1:2];
  assign lane     = EXMEM_AluRES[1:0];

  always_comb begin
    rdata      = mem[word_idx];
    byte_shift = rdata >> {lane, 3'b000};
    half_shift = rdata >> {lane[1], 4'b0000};

    unique case (exmem_funct3)
      3'b000:  load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_val = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_val = {24'b0, byte_shift[7:0]};
      3'b101:  load_val = {16'b0, half_shift[15:0]};
      default: load_val = rdata;
    endcase

    illegal    = (exmem_funct3 == 3'b011) || (exmem_funct3 == 3'b110) ||
                 (exmem_funct3 == 3'b111);
    misaligned = ((exmem_funct3[1:0] == 2'b01) && lane[0]) ||
                 ((exmem_funct3 == 3'b010) && (lane != 2'b00));
    fault      = (exmem_read || exmem_write) &&
                 ((exmem_read && exmem_write) || illegal || misaligned);

    byte_en = '0;
    wdata   = exmem_store_data;
    unique case (exmem_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wdata   = {4{exmem_store_data[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{exmem_store_data[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase

    // A flush only bubbles the incoming instruction; the one already in MEM
    // still completes, so only a plain stall suppresses the store.
    do_store = exmem_write && !fault && (flush || !stall);
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_store) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      EXMEM_rd         <= '0;
      EXMEM_AluRES     <= '0;
      EXMEM_WriteBack  <= 1'b0;
      exmem_read       <= 1'b0;
      exmem_write      <= 1'b0;
      exmem_funct3     <= '0;
      exmem_store_data <= '0;
      MEMWB_rd         <= '0;
      MEMWB_AluRES     <= '0;
      MEMWB_WriteBack  <= 1'b0;
      MEMWB_fault      <= 1'b0;
    end else begin
      if (flush) begin
        EXMEM_rd         <= '0;
        EXMEM_AluRES     <= '0;
        EXMEM_WriteBack  <= 1'b0;
        exmem_read       <= 1'b0;
        exmem_write      <= 1'b0;
        exmem_funct3     <= '0;
        exmem_store_data <= '0;
      end else if (!stall) begin
        EXMEM_rd         <= EX_rd;
        EXMEM_AluRES     <= EX_AluRES;
        EXMEM_WriteBack  <= EX_WriteBack;
        exmem_read       <= EX_MemoryRead;
        exmem_write      <= EX_MemoryWrite;
        exmem_funct3     <= EX_funct3;
        exmem_store_data <= EX_store_data;
      end

      if (stall && !flush) begin
        MEMWB_rd        <= '0;
        MEMWB_AluRES    <= '0;
        MEMWB_WriteBack <= 1'b0;
        MEMWB_fault     <= 1'b0;
      end else begin
        MEMWB_rd        <= EXMEM_rd;
        MEMWB_AluRES    <= (exmem_read && !fault) ? load_val : EXMEM_AluRES;
        MEMWB_WriteBack <= EXMEM_WriteBack && !exmem_write && !fault;
        MEMWB_fault     <= fault;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed pipeline scenarios plus randomized traffic
// checked against a byte-addressed reference memory and a one-deep pipeline model.
module tb_memory_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] EX_AluRES;
  logic [31:0] EX_store_data;
  logic [4:0]  EX_rd;
  logic [2:0]  EX_funct3;
  logic        EX_WriteBack;
  logic        EX_MemoryRead;
  logic        EX_MemoryWrite;
  logic        stall;
  logic        flush;
  logic [4:0]  EXMEM_rd;
  logic [31:0] EXMEM_AluRES;
  logic        EXMEM_WriteBack;
  logic [4:0]  MEMWB_rd;
  logic [31:0] MEMWB_AluRES;
  logic        MEMWB_WriteBack;
  logic        MEMWB_fault;

  memory_stage #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .EX_AluRES(EX_AluRES), .EX_store_data(EX_store_data), .EX_rd(EX_rd),
    .EX_funct3(EX_funct3), .EX_WriteBack(EX_WriteBack),
    .EX_MemoryRead(EX_MemoryRead), .EX_MemoryWrite(EX_MemoryWrite),
    .stall(stall), .flush(flush),
    .EXMEM_rd(EXMEM_rd), .EXMEM_AluRES(EXMEM_AluRES), .EXMEM_WriteBack(EXMEM_WriteBack),
    .MEMWB_rd(MEMWB_rd), .MEMWB_AluRES(MEMWB_AluRES), .MEMWB_WriteBack(MEMWB_WriteBack),
    .MEMWB_fault(MEMWB_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        wb;
    logic        mr;
    logic        mw;
  } ins_t;

  localparam int MEM_BYTES = 1024;

  logic [7:0]  mb [MEM_BYTES];
  ins_t        m_ex;
  logic [4:0]  e_rd;
  logic [31:0] e_alu;
  logic        e_wb;
  logic        e_fault;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic ins_t mk(input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] sd, input logic [2:0] f3,
                              input logic wb, input logic mr, input logic mw);
    ins_t t;
    t.rd = rd; t.alu = alu; t.sd = sd; t.f3 = f3; t.wb = wb; t.mr = mr; t.mw = mw;
    return t;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] mword(input int byte_addr);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w = w | (32'(mb[byte_addr + i]) << (8 * i));
    return w;
  endfunction

  // Model of one clock edge: retire the instruction in MEM, then advance EX/MEM.
  task automatic model_edge(input ins_t in, input logic st, input logic fl);
    int a, sz;
    logic flt;
    logic [31:0] val;
    if (st && !fl) begin
      e_rd = '0; e_alu = '0; e_wb = 1'b0; e_fault = 1'b0;
    end else begin
      a   = int'(m_ex.alu % MEM_BYTES);
      sz  = size_of(m_ex.f3);
      flt = (m_ex.mr || m_ex.mw) &&
            ((m_ex.mr && m_ex.mw) || sz == 0 || (sz != 0 && a % sz != 0));
      val = '0;
      if (m_ex.mr && !flt) begin
        for (int i = 0; i < sz; i++) val = val | (32'(mb[a + i]) << (8 * i));
        if (m_ex.f3 < 3'd4 && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
      end
      if (m_ex.mw && !flt)
        for (int i = 0; i < sz; i++) mb[a + i] = 8'(m_ex.sd >> (8 * i));
      e_rd    = m_ex.rd;
      e_alu   = (m_ex.mr && !flt) ? val : m_ex.alu;
      e_wb    = m_ex.wb && !m_ex.mw && !flt;
      e_fault = flt;
    end
    if (fl)       m_ex = '0;
    else if (!st) m_ex = in;
  endtask

  task automatic step(input ins_t in, input logic st, input logic fl);
    EX_rd = in.rd; EX_AluRES = in.alu; EX_store_data = in.sd; EX_funct3 = in.f3;
    EX_WriteBack = in.wb; EX_MemoryRead = in.mr; EX_MemoryWrite = in.mw;
    stall = st; flush = fl;
    @(posedge clk);
    model_edge(in, st, fl);
    #1;
    chk("exmem_rd", 32'(EXMEM_rd), 32'(m_ex.rd));
    chk("exmem_alu", EXMEM_AluRES, m_ex.alu);
    chk("exmem_wb", 32'(EXMEM_WriteBack), 32'(m_ex.wb));
    chk("memwb_wb", 32'(MEMWB_WriteBack), 32'(e_wb));
    chk("memwb_fault", 32'(MEMWB_fault), 32'(e_fault));
    if (e_wb) begin
      chk("memwb_rd", 32'(MEMWB_rd), 32'(e_rd));
      chk("memwb_alu", MEMWB_AluRES, e_alu);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exmem_rd"}, 32'(EXMEM_rd), 32'd0);
    chk({tag, "_exmem_alu"}, EXMEM_AluRES, 32'd0);
    chk({tag, "_exmem_wb"}, 32'(EXMEM_WriteBack), 32'd0);
    chk({tag, "_memwb_rd"}, 32'(MEMWB_rd), 32'd0);
    chk({tag, "_memwb_alu"}, MEMWB_AluRES, 32'd0);
    chk({tag, "_memwb_wb"}, 32'(MEMWB_WriteBack), 32'd0);
    chk({tag, "_memwb_fault"}, 32'(MEMWB_fault), 32'd0);
  endtask

  function automatic ins_t rand_ins();
    ins_t t;
    int kind, sz;
    t.rd = 5'($urandom); t.alu = $urandom; t.sd = $urandom;
    t.f3 = 3'($urandom); t.wb = 1'($urandom); t.mr = 1'b0; t.mw = 1'b0;
    kind = int'($urandom_range(0, 2));
    if (kind == 1) t.mr = 1'b1;
    if (kind == 2) t.mw = 1'b1;
    if ($urandom_range(0, 15) == 0) begin t.mr = 1'b1; t.mw = 1'b1; end
    if (kind != 0 && $urandom_range(0, 2) != 0) begin
      case ($urandom_range(0, 4))
        0: t.f3 = 3'd0; 1: t.f3 = 3'd1; 2: t.f3 = 3'd2; 3: t.f3 = 3'd4; default: t.f3 = 3'd5;
      endcase
      sz = size_of(t.f3);
      t.alu = t.alu & ~32'(sz - 1);
    end
    return t;
  endfunction

  ins_t nop;
  logic [31:0] old_word;

  initial begin
    clk = 1'b0; reset_n = 1'b0;
    nop = mk(5'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    EX_rd = '0; EX_AluRES = '0; EX_store_data = '0; EX_funct3 = '0;
    EX_WriteBack = 1'b0; EX_MemoryRead = 1'b0; EX_MemoryWrite = 1'b0;
    stall = 1'b0; flush = 1'b0;
    m_ex = '0; e_rd = '0; e_alu = '0; e_wb = 1'b0; e_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // Fill every word so later loads never read uninitialised storage.
    for (int i = 0; i < 256; i++) step(mk(5'd0, 32'(i * 4), $urandom, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);

    // SW then LW
    step(mk(5'd0, 32'h10, 32'hDEADBEEF, 3'd2, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(5'd5, 32'h10, 32'd0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t1_sw_wb", 32'(MEMWB_WriteBack), 32'd0);
    step(nop, 1'b0, 1'b0);
    chk("t1_lw_val", MEMWB_AluRES, 32'hDEADBEEF);
    chk("t1_lw_rd", 32'(MEMWB_rd), 32'd5);
    chk("t1_lw_wb", 32'(MEMWB_WriteBack), 32'd1);

    // SB then LB / LBU / LW
    step(mk(5'd0, 32'h13, 32'h80, 3'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(5'd1, 32'h13, 32'd0, 3'd0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(5'd2, 32'h13, 32'd0, 3'd4, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t2_lb", MEMWB_AluRES, 32'hFFFFFF80);
    step(mk(5'd3, 32'h10, 32'd0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t2_lbu", MEMWB_AluRES, 32'h00000080);
    step(nop, 1'b0, 1'b0);
    chk("t2_lw", MEMWB_AluRES, 32'h80ADBEEF);

    // Misaligned LH and SW
    step(mk(5'd4, 32'h11, 32'd0, 3'd1, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(5'd0, 32'h12, 32'h12345678, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    chk("t3_lh_fault", 32'(MEMWB_fault), 32'd1);
    chk("t3_lh_wb", 32'(MEMWB_WriteBack), 32'd0);
    step(mk(5'd6, 32'h10, 32'd0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t3_sw_fault", 32'(MEMWB_fault), 32'd1);
    step(nop, 1'b0, 1'b0);
    chk("t3_fault_clear", 32'(MEMWB_fault), 32'd0);
    chk("t3_word_kept", MEMWB_AluRES, 32'h80ADBEEF);

    // Stall, then flush with stall
    step(mk(5'd3, 32'd7, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(nop, 1'b1, 1'b0);
    chk("t4_hold_rd", 32'(EXMEM_rd), 32'd3);
    chk("t4_bubble_wb", 32'(MEMWB_WriteBack), 32'd0);
    step(nop, 1'b0, 1'b0);
    chk("t4_once_rd", 32'(MEMWB_rd), 32'd3);
    chk("t4_once_val", MEMWB_AluRES, 32'd7);
    step(nop, 1'b0, 1'b0);
    chk("t4_not_twice", 32'(MEMWB_WriteBack), 32'd0);
    step(mk(5'd9, 32'd99, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(mk(5'd10, 32'd5, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("t4_flush_wb", 32'(EXMEM_WriteBack), 32'd0);
    chk("t4_flush_rd", 32'(EXMEM_rd), 32'd0);

    // Address wrap
    step(mk(5'd0, 32'h400, 32'hCAFEF00D, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(5'd7, 32'h0, 32'd0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);
    chk("t5_wrap", MEMWB_AluRES, 32'hCAFEF00D);

    // Asynchronous reset kills the pending store
    old_word = mword(32'h20);
    step(mk(5'd0, 32'h20, 32'h55AA55AA, 3'd2, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("t6");
    @(posedge clk);
    #2 reset_n = 1'b1;
    m_ex = '0;
    step(mk(5'd8, 32'h20, 32'd0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);
    chk("t6_store_lost", MEMWB_AluRES, old_word);

    // Randomized traffic
    for (int n = 0; n < 500; n++)
      step(rand_ins(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    step(nop, 1'b0, 1'b0);
    step(nop, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
